scan_index_gen: RTL
===================

// Module: scan_index_gen
// PURPOSE
//  Parametrised scan-address generator for a WIDTH x HEIGHT image buffer feeding the edge detector.
//  Emits one linear pixel index per accepted beat in one of four scan orders: raster, column, anti-diagonal, diagonal.
//  Marks the last pixel of every line/column/diagonal so the detector resets its state, and flags end of frame.
//  Start/valid/enable handshake; scan mode is latched per frame.
// PARAMETERS
//  WIDTH   150                      pixels per row (>=2)
//  HEIGHT  150                      rows per frame (>=2)
//  IDX_W   $clog2(WIDTH*HEIGHT)     index width (15 at defaults)
// PORTS
//  clk         in   1      single clock, rising edge
//  resetIn_n   in   1      asynchronous, active-low reset
//  start       in   1      begin a frame; sampled only in IDLE
//  mode        in   2      scan order, latched on accepted start
//  en          in   1      downstream accepts current index (ready)
//  busy        out  1      frame in progress
//  valid       out  1      idx/line_end meaningful
//  idx         out  IDX_W  linear index = row*WIDTH + col
//  line_end    out  1      idx is last pixel of its current line
//  frame_done  out  1      one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, valid=0, idx=0, line_end=0, frame_done=0; row/col/diag-start regs=0.
//  FSM IDLE -> SCAN on start; SCAN -> DONE when valid&&en&&last pixel; DONE -> IDLE unconditionally.
//  start in SCAN/DONE ignored; mode changes mid-frame ignored until next accepted start.
//  Latency: first index valid the cycle after start. Beat accepted when valid&&en; en low holds all outputs.
//  valid=busy=1 only in SCAN; frame_done=1 only in DONE. Exactly WIDTH*HEIGHT beats per frame.
//  Modes (row r, col c, origin top-left):
//   0 LR: c++ ; at c=W-1: c=0,r++. line_end at c=W-1. idx +1.
//   1 UD: r++ ; at r=H-1: r=0,c++. line_end at r=H-1. idx +W; wrap idx-(H-1)*W+1.
//   2 DL: anti-diagonal d=r+c, d=0..W+H-2; start (r=d-min(d,W-1), c=min(d,W-1)); step r+1,c-1 (idx +W-1);
//         line ends at c=0 or r=H-1.
//   3 DR: diagonals start at (0,W-1),(0,W-2)..(0,0),(1,0)..(H-1,0); step r+1,c+1 (idx +W+1);
//         line ends at c=W-1 or r=H-1.
//  Diagonal next-start tracked in registers (start row/col/idx); no runtime multiplier.
//  line_end is registered with idx, so the pair always describes the same pixel.
//  Last pixel: LR/UD/DL idx=W*H-1; DR idx=(H-1)*W.
//  Async reset mid-frame aborts immediately to IDLE with reset values; no frame_done.
// CONFIGURATION
//  `SCAN_COORD_EN defined: adds ports row out $clog2(HEIGHT), col out $clog2(WIDTH), aligned with idx; same reset (0).
//  Undefined: ports absent; row/col remain internal only. Index behaviour identical either way.
// STRUCTURE
//  scan_pkg: mode encodings (SCAN_LR=0, SCAN_UD=1, SCAN_DL=2, SCAN_DR=3) and FSM state encodings.
//  Sub-module scan_step: combinational next (r,c,idx,line_end,last) from current position and latched mode.
//  Top holds FSM, position/diag-start registers and handshake.
// TESTING
//  Defaults, mode 0, en=1: idx 0..22499; line_end at 149,299,..,22499; frame_done pulse 1 cycle after 22499.
//  Defaults, mode 1: 0,150,..,22350 (line_end), 1,151,..; final 22499 with line_end; 22500 beats.
//  W=H=3, mode 2: 0|1,3|2,4,6|5,7|8 ('|' = line_end); W=4,H=2 mode 2: 0|1,4|2,5|3,6|7.
//  W=H=3, mode 3: 2|1,5|0,4,8|3,7|6; frame_done after 6.
//  en toggled randomly, mode 0: idx/line_end stable while en=0; sequence unchanged; start and mode change mid-frame ignored.
//  resetIn_n low mid-frame at idx 500: outputs 0 asynchronously; next start restarts at idx 0.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared encodings for the scan-address generator.
//   scan_mode_e  - scan order latched per frame
//   scan_state_e - frame FSM states
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_LR = 2'd0,  // raster, left to right, top to bottom
    SCAN_UD = 2'd1,  // column, top to bottom, left to right
    SCAN_DL = 2'd2,  // anti-diagonals, walking down-left
    SCAN_DR = 2'd3   // diagonals, walking down-right
  } scan_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_step.sv
// scan_step: combinational successor of the current scan position.
// Inputs : i_mode (latched scan order), current pixel i_row/i_col/i_idx and
//          start pixel of the current diagonal i_srow/i_scol/i_sidx.
// Outputs: next pixel o_row/o_col/o_idx with its o_line_end, the diagonal
//          start for the next pixel o_srow/o_scol/o_sidx, and o_last when
//          the current pixel is the final one of the frame.
module scan_step
  import scan_pkg::*;
#(
  parameter int WIDTH  = 150,
  parameter int HEIGHT = 150,
  parameter int IDX_W  = 15,
  parameter int RW     = 8,
  parameter int CW     = 8
) (
  input  scan_mode_e       i_mode,
  input  logic [RW-1:0]    i_row,
  input  logic [CW-1:0]    i_col,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [RW-1:0]    i_srow,
  input  logic [CW-1:0]    i_scol,
  input  logic [IDX_W-1:0] i_sidx,
  output logic [RW-1:0]    o_row,
  output logic [CW-1:0]    o_col,
  output logic [IDX_W-1:0] o_idx,
  output logic [RW-1:0]    o_srow,
  output logic [CW-1:0]    o_scol,
  output logic [IDX_W-1:0] o_sidx,
  output logic             o_line_end,
  output logic             o_last
);

  localparam logic [RW-1:0]    R_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]    C_LAST  = CW'(WIDTH - 1);
  localparam logic [IDX_W-1:0] W_I     = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] W_M1    = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] W_P1    = IDX_W'(WIDTH + 1);
  // column wrap: back to row 0, one column right
  localparam logic [IDX_W-1:0] UD_BACK = IDX_W'((HEIGHT - 1) * WIDTH - 1);

  function automatic logic le_of(scan_mode_e m, logic [RW-1:0] r, logic [CW-1:0] c);
    unique case (m)
      SCAN_LR: le_of = (c == C_LAST);
      SCAN_UD: le_of = (r == R_LAST);
      SCAN_DL: le_of = (c == '0) || (r == R_LAST);
      default: le_of = (c == C_LAST) || (r == R_LAST);
    endcase
  endfunction

  logic w_cur_le;

  always_comb begin
    o_row    = i_row;
    o_col    = i_col;
    o_idx    = i_idx;
    o_srow   = i_srow;
    o_scol   = i_scol;
    o_sidx   = i_sidx;
    w_cur_le = le_of(i_mode, i_row, i_col);
    o_last   = (i_row == R_LAST) &&
               ((i_mode == SCAN_DR) ? (i_col == '0) : (i_col == C_LAST));
    unique case (i_mode)
      SCAN_LR: begin
        o_idx = i_idx + 1'b1;
        if (i_col == C_LAST) begin
          o_col = '0;
          o_row = i_row + 1'b1;
        end else begin
          o_col = i_col + 1'b1;
        end
      end
      SCAN_UD: begin
        if (i_row == R_LAST) begin
          o_row = '0;
          o_col = i_col + 1'b1;
          o_idx = i_idx - UD_BACK;
        end else begin
          o_row = i_row + 1'b1;
          o_idx = i_idx + W_I;
        end
      end
      SCAN_DL: begin
        // Starts run along row 0 to the right edge, then down the right edge.
        if (w_cur_le) begin
          if (i_scol != C_LAST) begin
            o_scol = i_scol + 1'b1;
            o_sidx = i_sidx + 1'b1;
          end else begin
            o_srow = i_srow + 1'b1;
            o_sidx = i_sidx + W_I;
          end
          o_row = o_srow;
          o_col = o_scol;
          o_idx = o_sidx;
        end else begin
          o_row = i_row + 1'b1;
          o_col = i_col - 1'b1;
          o_idx = i_idx + W_M1;
        end
      end
      default: begin
        // Starts run along row 0 to the left edge, then down the left edge.
        if (w_cur_le) begin
          if ((i_srow == '0) && (i_scol != '0)) begin
            o_scol = i_scol - 1'b1;
            o_sidx = i_sidx - 1'b1;
          end else begin
            o_srow = i_srow + 1'b1;
            o_scol = '0;
            o_sidx = i_sidx + W_I;
          end
          o_row = o_srow;
          o_col = o_scol;
          o_idx = o_sidx;
        end else begin
          o_row = i_row + 1'b1;
          o_col = i_col + 1'b1;
          o_idx = i_idx + W_P1;
        end
      end
    endcase
    o_line_end = le_of(i_mode, o_row, o_col);
  end

endmodule

// File: rtl/scan_index_gen.sv
// scan_index_gen: scan-address generator for a WIDTH x HEIGHT image buffer.
// Emits one linear index (row*WIDTH+col) per accepted beat (valid && en) in
// raster, column, anti-diagonal or diagonal order; line_end marks the last
// pixel of each line, frame_done pulses once after the last pixel is taken.
// Ports: clk, resetIn_n (async low), start, mode[1:0], en (ready) in;
//        busy, valid, idx, line_end, frame_done out.
// Build option: define SCAN_COORD_EN to also expose row/col aligned with idx.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int WIDTH  = 150,
  parameter int HEIGHT = 150,
  parameter int IDX_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic             clk,
  input  logic             resetIn_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             line_end,
  output logic             frame_done
`ifdef SCAN_COORD_EN
  ,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col
`endif
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
  localparam logic [IDX_W-1:0] DR_IDX0 = IDX_W'(WIDTH - 1);

  scan_state_e      r_state;
  scan_mode_e       r_mode;
  logic [RW-1:0]    r_row, r_srow;
  logic [CW-1:0]    r_col, r_scol;
  logic [IDX_W-1:0] r_idx, r_sidx;
  logic             r_le, r_valid, r_done;

  logic [RW-1:0]    w_row, w_srow;
  logic [CW-1:0]    w_col, w_scol;
  logic [IDX_W-1:0] w_idx, w_sidx;
  logic             w_le, w_last;
  scan_mode_e       w_mode_in;

  assign w_mode_in = scan_mode_e'(mode);

  scan_step #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .IDX_W(IDX_W), .RW(RW), .CW(CW)
  ) u_step (
    .i_mode(r_mode), .i_row(r_row), .i_col(r_col), .i_idx(r_idx),
    .i_srow(r_srow), .i_scol(r_scol), .i_sidx(r_sidx),
    .o_row(w_row), .o_col(w_col), .o_idx(w_idx),
    .o_srow(w_srow), .o_scol(w_scol), .o_sidx(w_sidx),
    .o_line_end(w_le), .o_last(w_last)
  );

  always_ff @(posedge clk or negedge resetIn_n) begin
    if (!resetIn_n) begin
      r_state <= ST_IDLE;
      r_mode  <= SCAN_LR;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_srow  <= '0;
      r_scol  <= '0;
      r_sidx  <= '0;
      r_le    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // First pixel: (0,0) except DR, which opens at the top-right
            // corner. Both diagonal modes open on a one-pixel line.
            r_state <= ST_SCAN;
            r_mode  <= w_mode_in;
            r_valid <= 1'b1;
            r_row   <= '0;
            r_srow  <= '0;
            r_col   <= (w_mode_in == SCAN_DR) ? C_LAST : '0;
            r_scol  <= (w_mode_in == SCAN_DR) ? C_LAST : '0;
            r_idx   <= (w_mode_in == SCAN_DR) ? DR_IDX0 : '0;
            r_sidx  <= (w_mode_in == SCAN_DR) ? DR_IDX0 : '0;
            r_le    <= mode[1];
          end
        end
        ST_SCAN: begin
          if (en) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_le    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_row  <= w_row;
              r_col  <= w_col;
              r_idx  <= w_idx;
              r_srow <= w_srow;
              r_scol <= w_scol;
              r_sidx <= w_sidx;
              r_le   <= w_le;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_valid;
  assign valid      = r_valid;
  assign idx        = r_idx;
  assign line_end   = r_le;
  assign frame_done = r_done;

`ifdef SCAN_COORD_EN
  assign row = r_row;
  assign col = r_col;
`endif

endmodule
